// File: rtl/ycr_clk_gate_pkg.sv
// Shared mode encodings and channel state type for the multi-channel clock-gate controller.
package ycr_clk_gate_pkg;

  localparam logic [1:0] NCLK_GATE  = 2'b00;
  localparam logic [1:0] DYCLK_GATE = 2'b01;
  localparam logic [1:0] FOCLK_GATE = 2'b10;
  localparam logic [1:0] HSCLK_GATE = 2'b11;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    HYST  = 2'b01,
    REQ   = 2'b10,
    GATED = 2'b11
  } cg_state_t;

endpackage

// File: rtl/ctech_cells.sv
// Behavioural models of the technology cells: 2-flop reset-low synchronizer and latch-based clock gate.
module ctech_dsync_high #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      dout <= '0;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

module ctech_clk_gate (
  input  logic GATE,
  input  logic CLK,
  output logic GCLK
);

  logic en_lat;

  // Enable is captured while the clock is low so the gated clock never glitches.
  always_latch begin
    if (!CLK) en_lat <= GATE;
  end

  assign GCLK = CLK & en_lat;

endmodule

// File: rtl/ycr_clk_gate_ch.sv
// One gated-clock channel: input synchronizers, hysteresis/handshake FSM and the clock-gate cell.
module ycr_clk_gate_ch
  import ycr_clk_gate_pkg::*;
#(
  parameter int HCNT_W = 4
) (
  input  logic              clk_in,
  input  logic              reset_n,
  input  logic [1:0]        cfg_mode,
  input  logic [HCNT_W-1:0] hcnt_ss,
  input  logic              src_req,
  input  logic              dst_idle,
  input  logic              idle_ack,
  output logic              idle_req,
  output logic              clk_enb,
  output logic              clk_out,
  output logic              gate_sts,
  output logic              wake_pulse
);

  cg_state_t         state;
  logic [HCNT_W-1:0] cnt;
  logic [1:0]        mode_ss;
  logic [1:0]        mode_q;
  logic              src_req_ss;
  logic              dst_idle_ss;
  logic              idle_ack_ss;
  logic              wake;
  logic              dyn_mode;
  logic              hs_mode;
  logic              exit_gate;

  ctech_dsync_high #(.W(5)) u_sync (
    .clk   (clk_in),
    .rst_n (reset_n),
    .din   ({cfg_mode, src_req, dst_idle, idle_ack}),
    .dout  ({mode_ss, src_req_ss, dst_idle_ss, idle_ack_ss})
  );

  assign wake      = src_req_ss | ~dst_idle_ss;
  assign hs_mode   = (mode_ss == HSCLK_GATE);
  assign dyn_mode  = (mode_ss == DYCLK_GATE) | hs_mode;
  assign exit_gate = wake | (hs_mode & ~idle_ack_ss);

  // Wake requests reopen the clock combinationally, before the FSM leaves GATED.
  always_comb begin
    clk_enb = 1'b1;
    case (mode_ss)
      NCLK_GATE:  clk_enb = 1'b1;
      FOCLK_GATE: clk_enb = 1'b0;
      default:    clk_enb = !((state == GATED) && !exit_gate);
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state      <= RUN;
      cnt        <= '0;
      idle_req   <= 1'b0;
      gate_sts   <= 1'b0;
      wake_pulse <= 1'b0;
      mode_q     <= NCLK_GATE;
    end else begin
      mode_q     <= mode_ss;
      gate_sts   <= ~clk_enb;
      wake_pulse <= 1'b0;
      if ((mode_ss != mode_q) || !dyn_mode) begin
        state    <= RUN;
        cnt      <= '0;
        idle_req <= 1'b0;
      end else begin
        case (state)
          RUN: begin
            if (!wake) begin
              cnt   <= hcnt_ss;
              state <= HYST;
            end
          end
          HYST: begin
            if (wake) begin
              state <= RUN;
            end else if (cnt == '0) begin
              if (hs_mode) begin
                state    <= REQ;
                idle_req <= 1'b1;
              end else begin
                state <= GATED;
              end
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          REQ: begin
            if (wake) begin
              state    <= RUN;
              idle_req <= 1'b0;
            end else if (idle_ack_ss) begin
              state <= GATED;
            end
          end
          GATED: begin
            if (exit_gate) begin
              state      <= RUN;
              idle_req   <= 1'b0;
              wake_pulse <= 1'b1;
            end
          end
          default: state <= RUN;
        endcase
      end
    end
  end

  ctech_clk_gate u_cg (
    .GATE (clk_enb),
    .CLK  (clk_in),
    .GCLK (clk_out)
  );

endmodule

// File: rtl/ycr_clk_gate_mc.sv
// Multi-channel clock-gate controller: NCH independent channels sharing one synchronized hysteresis count.
module ycr_clk_gate_mc
  import ycr_clk_gate_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int HCNT_W = 4
) (
  input  logic              clk_in,
  input  logic              reset_n,
  input  logic [2*NCH-1:0]  cfg_mode,
  input  logic [HCNT_W-1:0] cfg_hcnt,
  input  logic [NCH-1:0]    src_req,
  input  logic [NCH-1:0]    dst_idle,
  input  logic [NCH-1:0]    idle_ack,
  output logic [NCH-1:0]    idle_req,
  output logic [NCH-1:0]    clk_enb,
  output logic [NCH-1:0]    clk_out,
  output logic [NCH-1:0]    gate_sts,
  output logic [NCH-1:0]    wake_pulse
);

  logic [HCNT_W-1:0] hcnt_ss;

  ctech_dsync_high #(.W(HCNT_W)) u_hcnt_sync (
    .clk   (clk_in),
    .rst_n (reset_n),
    .din   (cfg_hcnt),
    .dout  (hcnt_ss)
  );

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    ycr_clk_gate_ch #(.HCNT_W(HCNT_W)) u_ch (
      .clk_in     (clk_in),
      .reset_n    (reset_n),
      .cfg_mode   (cfg_mode[2*i+1:2*i]),
      .hcnt_ss    (hcnt_ss),
      .src_req    (src_req[i]),
      .dst_idle   (dst_idle[i]),
      .idle_ack   (idle_ack[i]),
      .idle_req   (idle_req[i]),
      .clk_enb    (clk_enb[i]),
      .clk_out    (clk_out[i]),
      .gate_sts   (gate_sts[i]),
      .wake_pulse (wake_pulse[i])
    );
  end

endmodule
